// File: rtl/tof_sequencer.sv
// Ultrasound time-of-flight sequencer: TX burst, receive blanking,
// first-echo-edge capture or timeout, result on a valid/ready port.
module tof_sequencer #(
    parameter int CNT_WIDTH    = 16,
    parameter int BURST_WIDTH  = 4,
    parameter int HP_WIDTH     = 8,
    parameter int ECHO_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic [HP_WIDTH-1:0]    half_period,
    input  logic [CNT_WIDTH-1:0]   blank_cycles,
    input  logic [CNT_WIDTH-1:0]   timeout_cycles,
    input  logic                   echo_in,
    output logic                   tx_out,
    output logic                   busy,
    output logic                   meas_valid,
    input  logic                   meas_ready,
    output logic [CNT_WIDTH-1:0]   meas_tof,
    output logic                   meas_timeout
);

    localparam int HALF_W = BURST_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        BURST,
        BLANK,
        LISTEN,
        REPORT
    } state_t;

    state_t state, state_n;

    logic [BURST_WIDTH-1:0] bl_q;
    logic [HP_WIDTH-1:0]    hp_q;
    logic [CNT_WIDTH-1:0]   blank_q;
    logic [CNT_WIDTH-1:0]   timeout_q;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [HP_WIDTH-1:0]    hp_cnt;
    logic [HALF_W-1:0]      half_cnt;
    logic                   echo_q;

    logic                   edge_det;
    logic                   hp_end;
    logic                   burst_end;
    logic                   timed_out;
    logic                   blank_end;
    logic                   accept;
    logic [CNT_WIDTH-1:0]   echo_tof;

    assign busy = (state != IDLE);

    // Next-state decode and per-cycle condition flags
    always_comb begin
        state_n   = state;
        edge_det  = echo_in && !echo_q;
        hp_end    = (hp_cnt == hp_q - HP_WIDTH'(1));
        burst_end = hp_end && (half_cnt == {bl_q, 1'b0} - HALF_W'(1));
        timed_out = (cnt >= timeout_q);
        blank_end = (cnt >= blank_q);
        accept    = meas_valid && meas_ready;
        echo_tof  = '0;
        if (cnt >= CNT_WIDTH'(ECHO_LATENCY)) begin
            echo_tof = cnt - CNT_WIDTH'(ECHO_LATENCY);
        end
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = (burst_len == '0) ? BLANK : BURST;
                end
            end
            BURST: begin
                if (abort)          state_n = IDLE;
                else if (burst_end) state_n = BLANK;
            end
            BLANK: begin
                if (abort)          state_n = IDLE;
                else if (timed_out) state_n = REPORT;
                else if (blank_end) state_n = LISTEN;
            end
            LISTEN: begin
                if (abort)                      state_n = IDLE;
                else if (edge_det || timed_out) state_n = REPORT;
            end
            REPORT: begin
                if (accept) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Snapshot of the configuration taken when a measurement starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bl_q      <= '0;
            hp_q      <= '0;
            blank_q   <= '0;
            timeout_q <= '0;
        end else if (state == IDLE && start) begin
            bl_q      <= burst_len;
            hp_q      <= (half_period == '0) ? HP_WIDTH'(1) : half_period;
            blank_q   <= blank_cycles;
            timeout_q <= timeout_cycles;
        end
    end

    // Saturating time-of-flight counter, frozen in IDLE and REPORT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            if (start) cnt <= '0;
        end else if (state != REPORT && cnt != '1) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    // TX square wave: hp-cycle half periods, 2*burst_len of them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_out   <= 1'b0;
            hp_cnt   <= '0;
            half_cnt <= '0;
        end else if (state == IDLE) begin
            hp_cnt   <= '0;
            half_cnt <= '0;
            tx_out   <= start && (burst_len != '0);
        end else if (state == BURST && !abort) begin
            if (hp_end) begin
                hp_cnt   <= '0;
                half_cnt <= half_cnt + HALF_W'(1);
                tx_out   <= burst_end ? 1'b0 : ~tx_out;
            end else begin
                hp_cnt <= hp_cnt + HP_WIDTH'(1);
            end
        end else begin
            tx_out <= 1'b0;
        end
    end

    // Echo history, updated in every state so a level is never an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) echo_q <= 1'b0;
        else        echo_q <= echo_in;
    end

    // Result capture on entry to REPORT; valid drops after the transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid   <= 1'b0;
            meas_tof     <= '0;
            meas_timeout <= 1'b0;
        end else if (state != REPORT && state_n == REPORT) begin
            meas_valid <= 1'b1;
            if (state == LISTEN && edge_det) begin
                meas_tof     <= echo_tof;
                meas_timeout <= 1'b0;
            end else begin
                meas_tof     <= timeout_q;
                meas_timeout <= 1'b1;
            end
        end else if (accept) begin
            meas_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tof_sequencer.sv
// Bench for tof_sequencer: directed measurements against an
// outcome-level model of burst, blanking, echo and timeout.
module tb_tof_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  burst_len;
    logic [7:0]  half_period;
    logic [15:0] blank_cycles;
    logic [15:0] timeout_cycles;
    logic        echo_in;
    logic        tx_out;
    logic        busy;
    logic        meas_valid;
    logic        meas_ready;
    logic [15:0] meas_tof;
    logic        meas_timeout;

    tof_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .burst_len      (burst_len),
        .half_period    (half_period),
        .blank_cycles   (blank_cycles),
        .timeout_cycles (timeout_cycles),
        .echo_in        (echo_in),
        .tx_out         (tx_out),
        .busy           (busy),
        .meas_valid     (meas_valid),
        .meas_ready     (meas_ready),
        .meas_tof       (meas_tof),
        .meas_timeout   (meas_timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    bit          chk_on = 1'b0;
    bit          exp_tx;
    bit          exp_busy;
    bit          exp_valid;
    int          exp_tof;
    bit          exp_to;

    int          tx_hi;
    bit          valid_seen;
    int          last_tof;
    bit          last_to;

    bit          echo_lvl [0:4095];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, req, $time);
        end
    endtask

    // Cycle-by-cycle comparison of DUT outputs with the model's view
    always @(negedge clk) begin
        if (chk_on) begin
            check("tx_out", {31'b0, tx_out}, {31'b0, exp_tx});
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            check("meas_valid", {31'b0, meas_valid}, {31'b0, exp_valid});
            if (exp_valid) begin
                check("meas_tof", {16'b0, meas_tof}, exp_tof);
                check("meas_timeout", {31'b0, meas_timeout},
                      {31'b0, exp_to});
            end
            if (tx_out) tx_hi++;
            if (meas_valid) begin
                valid_seen = 1'b1;
                last_tof   = int'(meas_tof);
                last_to    = meas_timeout;
            end
        end
    end

    task automatic clear_echo();
        for (int i = 0; i < 4096; i++) echo_lvl[i] = 1'b0;
    endtask

    task automatic set_echo(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) echo_lvl[i] = 1'b1;
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        abort      = 1'b0;
        echo_in    = 1'b0;
        meas_ready = 1'b0;
    endtask

    task automatic expect_idle();
        exp_tx    = 1'b0;
        exp_busy  = 1'b0;
        exp_valid = 1'b0;
    endtask

    // One measurement. abort_at = counter value at which abort is
    // raised (-1: never); hold = REPORT cycles with ready low.
    task automatic run_meas(input int bl, input int hp, input int blank,
                            input int tmo, input int abort_at,
                            input int hold, input bit start_abort);
        int  hpe, b, lst, d, tof, last;
        bit  is_to, aborted;
        hpe = (hp == 0) ? 1 : hp;
        b   = 2 * bl * hpe;
        lst = (b > blank) ? b : blank;
        d   = -1;
        is_to = 1'b0;
        tof   = 0;
        if (tmo <= lst) begin
            d     = (b > tmo) ? b : tmo;
            is_to = 1'b1;
            tof   = tmo;
        end else begin
            for (int c = lst + 1; d < 0; c++) begin
                if (echo_lvl[c] && !echo_lvl[c-1]) begin
                    d   = c;
                    tof = (c >= 2) ? c - 2 : 0;
                end else if (c >= tmo) begin
                    d     = c;
                    is_to = 1'b1;
                    tof   = tmo;
                end
            end
        end
        aborted = (abort_at >= 0) && (abort_at <= d);
        last    = aborted ? abort_at : d;
        tx_hi      = 0;
        valid_seen = 1'b0;

        @(posedge clk); #1;
        idle_inputs();
        start          = 1'b1;
        abort          = start_abort;
        burst_len      = 4'(bl);
        half_period    = 8'(hp);
        blank_cycles   = 16'(blank);
        timeout_cycles = 16'(tmo);
        expect_idle();

        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            start          = (k % 3 == 0);
            burst_len      = 4'($urandom);
            half_period    = 8'($urandom);
            blank_cycles   = 16'($urandom);
            timeout_cycles = 16'($urandom);
            echo_in        = echo_lvl[k];
            abort          = (k == abort_at);
            exp_busy       = 1'b1;
            exp_tx         = (k < b) && ((k / hpe) % 2 == 0);
            exp_valid      = 1'b0;
        end

        if (!aborted) begin
            for (int h = 0; h <= hold; h++) begin
                @(posedge clk); #1;
                meas_ready = (h == hold);
                start      = h[0];
                echo_in    = h[0];
                abort      = h[0];
                exp_tx     = 1'b0;
                exp_busy   = 1'b1;
                exp_valid  = 1'b1;
                exp_tof    = tof;
                exp_to     = is_to;
            end
        end

        repeat (2) begin
            @(posedge clk); #1;
            idle_inputs();
            expect_idle();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        burst_len      = 4'd0;
        half_period    = 8'd0;
        blank_cycles   = 16'd0;
        timeout_cycles = 16'd0;
        idle_inputs();
        expect_idle();
        clear_echo();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_tx", {31'b0, tx_out}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_valid", {31'b0, meas_valid}, 0);
        check("rst_tof", {16'b0, meas_tof}, 0);
        check("rst_timeout", {31'b0, meas_timeout}, 0);

        // reset asserted mid-burst
        @(posedge clk); #1;
        start       = 1'b1;
        burst_len   = 4'd4;
        half_period = 8'd5;
        blank_cycles   = 16'd10;
        timeout_cycles = 16'd100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("burst_busy", {31'b0, busy}, 1);
        check("burst_tx", {31'b0, tx_out}, 1);
        rst_n = 1'b0;
        #1;
        check("arst_tx", {31'b0, tx_out}, 0);
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_valid", {31'b0, meas_valid}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_idle();
        chk_on = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // normal echo at counter 150
        clear_echo();
        set_echo(150, 200);
        run_meas(2, 3, 20, 1000, -1, 2, 1'b0);
        check("norm_tof", last_tof, 148);
        check("norm_to", {31'b0, last_to}, 0);
        check("norm_txhi", tx_hi, 6);

        // pulse inside blanking is ignored
        clear_echo();
        set_echo(10, 30);
        set_echo(60, 80);
        run_meas(2, 3, 20, 1000, -1, 1, 1'b0);
        check("blank_tof", last_tof, 58);

        // plain timeout
        clear_echo();
        run_meas(1, 4, 20, 500, -1, 0, 1'b0);
        check("tmo_tof", last_tof, 500);
        check("tmo_flag", {31'b0, last_to}, 1);

        // echo on the timeout cycle wins
        clear_echo();
        set_echo(500, 520);
        run_meas(1, 4, 20, 500, -1, 0, 1'b0);
        check("edge_tof", last_tof, 498);
        check("edge_flag", {31'b0, last_to}, 0);

        // backpressure with start/echo/abort noise
        clear_echo();
        set_echo(40, 45);
        run_meas(1, 2, 10, 300, -1, 20, 1'b0);
        check("bp_tof", last_tof, 38);

        // abort during blanking
        clear_echo();
        set_echo(60, 70);
        run_meas(1, 2, 40, 100, 20, 0, 1'b0);
        check("abort_blank", {31'b0, valid_seen}, 0);

        // abort during burst
        clear_echo();
        run_meas(3, 4, 30, 100, 5, 0, 1'b0);
        check("abort_burst", {31'b0, valid_seen}, 0);

        // zero-length burst
        clear_echo();
        set_echo(15, 20);
        run_meas(0, 5, 10, 30, -1, 1, 1'b0);
        check("bl0_txhi", tx_hi, 0);
        check("bl0_tof", last_tof, 13);

        // zero half-period toggles every cycle
        clear_echo();
        set_echo(12, 14);
        run_meas(3, 0, 8, 60, -1, 1, 1'b0);
        check("hp0_txhi", tx_hi, 3);
        check("hp0_tof", last_tof, 10);

        // timeout below blank window
        clear_echo();
        set_echo(40, 45);
        run_meas(1, 2, 50, 30, -1, 0, 1'b0);
        check("tle_tof", last_tof, 30);
        check("tle_flag", {31'b0, last_to}, 1);

        // timeout reached during burst fires on first blank cycle
        clear_echo();
        run_meas(4, 10, 10, 50, -1, 0, 1'b0);
        check("tburst_tof", last_tof, 50);

        // level already high at listen start, then a real edge
        clear_echo();
        set_echo(15, 40);
        set_echo(50, 55);
        run_meas(1, 2, 20, 200, -1, 0, 1'b0);
        check("lvl_tof", last_tof, 48);

        // edge on the first listen cycle
        clear_echo();
        set_echo(21, 25);
        run_meas(1, 2, 20, 200, -1, 0, 1'b0);
        check("first_tof", last_tof, 19);

        // start and abort together in idle: start wins
        clear_echo();
        set_echo(30, 33);
        run_meas(1, 3, 10, 100, -1, 0, 1'b1);
        check("sa_valid", {31'b0, valid_seen}, 1);
        check("sa_tof", last_tof, 28);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tof_sequencer.md
Name: tof_sequencer

Overview:
Sequences one ultrasound time-of-flight measurement. On `start` it emits a square-wave transmit burst and starts a cycle counter. It blanks receive ringing, then waits for the first rising edge of the conditioned echo signal, or for a timeout. The result is presented on a valid/ready output with the fixed echo-path latency subtracted. It sits between the host/config logic and the transducer TX driver / echo comparator path.

Parameters:
CNT_WIDTH, 16, width of the TOF counter, blank/timeout config and result.
BURST_WIDTH, 4, width of the burst pulse-count config.
HP_WIDTH, 8, width of the half-period config.
ECHO_LATENCY, 2, fixed cycles of delay already applied to `echo_in` upstream; subtracted from the result.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin measurement; sampled only in IDLE.
abort  in  1  cancel measurement; effective in BURST/BLANK/LISTEN.
burst_len  in  BURST_WIDTH  number of full TX periods.
half_period  in  HP_WIDTH  cycles per TX half-period; 0 is treated as 1.
blank_cycles  in  CNT_WIDTH  counter value at which listening begins.
timeout_cycles  in  CNT_WIDTH  counter value at which the measurement gives up.
echo_in  in  1  synchronized echo comparator output, delayed by ECHO_LATENCY.
tx_out  out  1  transducer drive square wave.
busy  out  1  high in every state except IDLE.
meas_valid  out  1  result valid.
meas_ready  in  1  consumer accepts result.
meas_tof  out  CNT_WIDTH  echo arrival, in cycles from burst start.
meas_timeout  out  1  result is a timeout, not an echo.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state IDLE; `tx_out`, `busy`, `meas_valid`, `meas_timeout` = 0; `meas_tof` = 0; counter and echo-history register = 0.
- Reset asserted mid-measurement forces IDLE immediately; no result is produced.
- States: IDLE, BURST, BLANK, LISTEN, REPORT.
- IDLE:
  - `start`=1 at cycle T latches `burst_len`, `half_period`, `blank_cycles` and `timeout_cycles`.
  - At T+1: counter = 0 and `busy` = 1.
  - State becomes BURST with `tx_out`=1, or BLANK if the latched `burst_len`=0.
  - Config changes during a measurement have no effect.
- Counter: increments by 1 every cycle outside IDLE/REPORT; saturates at all-ones.
- BURST:
  - `tx_out` toggles every hp cycles, where hp = max(half_period, 1).
  - Runs exactly 2*burst_len half-periods (each half-period is hp cycles), then `tx_out`=0 and state becomes BLANK.
  - Example: burst_len=3, hp=2 gives `tx_out` = 1,1,0,0 repeated 3 times (12 cycles).
- BLANK: moves to LISTEN on the cycle the counter reaches `blank_cycles`. If already ≥ `blank_cycles` on entry, moves immediately.
- Echo edge = `echo_in`=1 while the previous-cycle `echo_in`=0. The history register updates every cycle in every state, so an echo already high when LISTEN begins is not an edge.
- LISTEN, edge at counter value C: go to REPORT with `meas_tof` = C − ECHO_LATENCY (saturate at 0) and `meas_timeout`=0. `meas_valid`=1 on the next cycle.
- Timeout: in BLANK or LISTEN, the counter reaching `timeout_cycles` goes to REPORT with `meas_tof` = `timeout_cycles` and `meas_timeout`=1.
- Priority: if an edge and the timeout occur on the same cycle, the edge wins.
- `timeout_cycles` ≤ `blank_cycles` always yields a timeout.
- Timeout is not checked in BURST; if reached during BURST, the timeout fires on the first BLANK cycle.
- REPORT:
  - `meas_valid`, `meas_tof` and `meas_timeout` are held stable until `meas_valid` && `meas_ready`.
  - Next cycle: IDLE, `meas_valid`=0, `busy`=0.
  - `start` is ignored in REPORT and in the transfer cycle; a new measurement needs `start` in IDLE.
- Abort: in BURST/BLANK/LISTEN, the next cycle is IDLE with `tx_out`=0 and no result. `abort` is ignored in IDLE and REPORT, to keep the handshake stable.
- `start` and `abort` asserted together in IDLE: start wins, since abort has no effect in IDLE.

Test Plan:
- Reset/idle: assert `rst_n`=0 mid-BURST, then release and hold idle 10 cycles → `tx_out`=0, `busy`=0, `meas_valid`=0 immediately and throughout.
- Normal echo: burst_len=2, half_period=3, blank=20, timeout=1000, ECHO_LATENCY=2; `echo_in` rises at counter 150 → `tx_out` shows 2 periods of 3-high/3-low; `meas_tof`=148, `meas_timeout`=0, `meas_valid` one cycle after the edge.
- Blanking: `echo_in` pulses at counter 10 and stays high through counter 30 (blank=20), then falls and rises again at 60 → the first pulse is ignored; `meas_tof`=58.
- Timeout and boundary: no echo, timeout=500 → `meas_tof`=500, `meas_timeout`=1. Then repeat with the echo rising exactly at counter 500 → echo result, `meas_tof`=498.
- Backpressure: hold `meas_ready`=0 for 20 cycles while toggling `start` and `echo_in` → outputs stable and `busy`=1. Release → one transfer, then IDLE.
- Abort and corner config: `abort` during BLANK → IDLE next cycle, no `meas_valid`. Then burst_len=0 → `tx_out` never rises. Then half_period=0 → `tx_out` toggles every cycle.
